train_track_model: RTL
======================

Name: train_track_model

Overview:
- Behavioural plant model of the two-train shared-track layout, sitting at the opposite end of the controller interface.
- Consumes switch setting SW[3:1] and drive commands DA/DB; advances two train positions around their loops.
- Produces the sensor vector SR[4:1] that the controller reads.
- Flags misroutes and shared-segment collisions so closed-loop benches can check controller safety.

Parameters:
- LOOP_LEN, 16: positions per loop, indexed 0..LOOP_LEN-1.
- POS_W, 4: position register width; must satisfy 2^POS_W >= LOOP_LEN.
- APPROACH_POS, 4: approach sensor position. Must equal ENTRY_POS-1.
- ENTRY_POS, 5: first position of the shared segment.
- EXIT_POS, 8: exit sensor position, i.e. the first position past the shared segment. Shared segment is ENTRY_POS..EXIT_POS-1.
- SPEED_DIV, 4: clocks per movement tick.
- A_START, 0: reset position of train A.
- B_START, 2: reset position of train B.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- SW  in  3  switch setting. 3'b000 routes A into the shared segment; 3'b011 routes B; any other value routes neither.
- DA  in  2  train A drive. 2'b01 = forward; any other value = stopped.
- DB  in  2  train B drive, same encoding as DA.
- SR  out  4  sensors.
  - SR[1] = A at APPROACH_POS.
  - SR[2] = B at APPROACH_POS.
  - SR[3] = B at EXIT_POS.
  - SR[4] = A at EXIT_POS.
- POS_A  out  POS_W  train A position.
- POS_B  out  POS_W  train B position.
- FAULT_A  out  1  sticky: A attempted entry without route.
- FAULT_B  out  1  sticky: B attempted entry without route.
- COLLIDE  out  1  sticky: both trains inside the shared segment at once.

Behaviour:
- Reset (RESET=0, asynchronous, effective immediately including mid-operation):
  - POS_A=A_START, POS_B=B_START.
  - Tick counter=0.
  - FAULT_A, FAULT_B, COLLIDE = 0.
  - SR follows the reset positions (0000 with defaults).
- Tick generation:
  - Counter counts 0..SPEED_DIV-1 and wraps.
  - Tick = cycle where the counter equals SPEED_DIV-1.
  - First tick is SPEED_DIV clocks after reset release.
- Per-train state machine, evaluated independently for A and B:
  - States: STOPPED, MOVING, FAULTED.
  - STOPPED <-> MOVING each cycle from drive==2'b01.
  - FAULTED is absorbing until reset; drive is ignored in FAULTED.
- Movement on a tick, train in MOVING:
  - Position advances to (pos+1) mod LOOP_LEN.
  - Exception: pos==APPROACH_POS and SW does not route this train. Position holds, the train enters FAULTED, and FAULT_x sets.
- Latency: positions update on the tick edge. SR is a pure decode of the position registers and is valid that same cycle. SR stays at level for as long as a train sits on a sensor position; a train stopped at APPROACH_POS keeps its SR bit asserted.
- Simultaneous entry attempts on one tick: the routed train enters; the unrouted train faults. With an invalid SW, both fault.
- Collision check: COLLIDE sets on any cycle where both POS_A and POS_B lie in ENTRY_POS..EXIT_POS-1. It is sticky until reset. Movement continues after COLLIDE.
- Wrap: LOOP_LEN-1 -> 0 with no special handling.
- SW changes while a train is inside the shared segment have no effect on that train; route is checked only at entry.
- Width rule: POS_W must satisfy 2^POS_W >= LOOP_LEN. Out-of-range parameter values are a configuration error with no runtime check.

Optional Feature:
- Macro: TRAIN_LAP_COUNT_EN.
- When defined, adds outputs LAPS_A and LAPS_B, 8 bits each.
  - Reset value 0.
  - Each increments when its train wraps LOOP_LEN-1 -> 0.
  - Saturates at 255.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold RESET=0 with DA=DB=01 for 10 clocks -> POS_A=0, POS_B=2, SR=0000, all flags 0, no movement. Assert RESET=0 mid-run at POS_A=6 -> POS_A returns to 0 in the same cycle.
- Routed A run: DA=01, DB=00, SW=000 from reset release ->
  - POS_A=4 at clock 16 (SR[1]=1).
  - POS_A=5 at clock 20.
  - SR[4]=1 at clock 32.
  - POS_A=0 at clock 64.
  - POS_B stays 2; no flags set.
- Misroute: DA=01, SW=011 -> POS_A holds 4 from clock 16. FAULT_A=1 at clock 20, SR[1] stays 1, POS_A never changes again.
- Collision: DA=DB=01, SW=011 until clock 14, then SW=000 ->
  - B enters at clock 12.
  - A enters at clock 20 with POS_B=7.
  - COLLIDE=1 at clock 20 and stays 1.
- Held stop: DB=01 until POS_B=4, then DB=00 for 40 clocks -> POS_B=4 and SR[2]=1 throughout. Setting DB=01 with SW=011 -> POS_B=5 at the next tick.
- Simultaneous entry: both trains at APPROACH_POS, SW=000, DA=DB=01 on the same tick -> POS_A=5, POS_B=4, FAULT_B=1, FAULT_A=0, COLLIDE=0.

Source files
------------

// File: rtl/train_track_model.sv
// train_track_model: behavioural plant for the two-train shared-track layout.
// Two trains circle independent loops that merge into one shared segment
// (ENTRY_POS..EXIT_POS-1). The switch SW grants one train at a time; a train
// that reaches the approach sensor unrouted stops there and faults. Both
// trains inside the shared segment at once raises a sticky COLLIDE.
// Optional build macro TRAIN_LAP_COUNT_EN adds saturating 8-bit lap counters
// LAPS_A / LAPS_B.

// Per-train movement unit: STOPPED/MOVING/FAULTED state plus loop position.
module train_track_unit #(
  parameter int LOOP_LEN     = 16,
  parameter int POS_W        = 4,
  parameter int APPROACH_POS = 4,
  parameter int START_POS    = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_fwd,
  input  logic             i_routed,
  output logic [POS_W-1:0] o_pos,
  output logic             o_fault
`ifdef TRAIN_LAP_COUNT_EN
  ,
  output logic             o_wrap
`endif
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_MOVING  = 2'd1,
    ST_FAULTED = 2'd2
  } state_t;

  localparam logic [POS_W-1:0] LP_LAST     = POS_W'(LOOP_LEN - 1);
  localparam logic [POS_W-1:0] LP_APPROACH = POS_W'(APPROACH_POS);
  localparam logic [POS_W-1:0] LP_START    = POS_W'(START_POS);

  state_t           r_state, w_state_nxt;
  logic [POS_W-1:0] r_pos, w_pos_nxt;
  logic             w_wrap;

  // State and position registers; async reset puts the train on its start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_STOPPED;
      r_pos   <= LP_START;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
    end
  end

  // Next state / position: drive selects stop or move every cycle; a moving
  // train advances on a tick unless it is blocked at approach without a route.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_wrap      = 1'b0;
    case (r_state)
      ST_STOPPED: begin
        if (i_fwd) w_state_nxt = ST_MOVING;
      end
      ST_MOVING: begin
        w_state_nxt = i_fwd ? ST_MOVING : ST_STOPPED;
        if (i_tick) begin
          if (r_pos == LP_APPROACH && !i_routed) begin
            // Misroute: hold at the approach sensor forever.
            w_state_nxt = ST_FAULTED;
          end else if (r_pos == LP_LAST) begin
            w_pos_nxt = '0;
            w_wrap    = 1'b1;
          end else begin
            w_pos_nxt = r_pos + 1'b1;
          end
        end
      end
      ST_FAULTED: begin
        w_state_nxt = ST_FAULTED;
      end
      default: begin
        w_state_nxt = ST_STOPPED;
      end
    endcase
  end

  assign o_pos   = r_pos;
  assign o_fault = (r_state == ST_FAULTED);
`ifdef TRAIN_LAP_COUNT_EN
  assign o_wrap  = w_wrap;
`endif

endmodule

// Top: tick divider, route decode, two train units, sensors and collision.
module train_track_model #(
  parameter int LOOP_LEN     = 16,
  parameter int POS_W        = 4,
  parameter int APPROACH_POS = 4,
  parameter int ENTRY_POS    = 5,
  parameter int EXIT_POS     = 8,
  parameter int SPEED_DIV    = 4,
  parameter int A_START      = 0,
  parameter int B_START      = 2
) (
  input  logic             Clock,
  input  logic             RESET,
  input  logic [2:0]       SW,
  input  logic [1:0]       DA,
  input  logic [1:0]       DB,
  output logic [4:1]       SR,
  output logic [POS_W-1:0] POS_A,
  output logic [POS_W-1:0] POS_B,
  output logic             FAULT_A,
  output logic             FAULT_B,
  output logic             COLLIDE
`ifdef TRAIN_LAP_COUNT_EN
  ,
  output logic [7:0]       LAPS_A,
  output logic [7:0]       LAPS_B
`endif
);

  localparam int CNT_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(SPEED_DIV - 1);
  localparam logic [POS_W-1:0] LP_APPROACH = POS_W'(APPROACH_POS);
  localparam logic [POS_W-1:0] LP_ENTRY    = POS_W'(ENTRY_POS);
  localparam logic [POS_W-1:0] LP_EXIT     = POS_W'(EXIT_POS);

  logic [CNT_W-1:0] r_cnt;
  logic             r_collide;
  logic             w_tick;
  logic             w_route_a, w_route_b;
  logic             w_a_in, w_b_in, w_both_in;
  logic [POS_W-1:0] w_pos_a, w_pos_b;
  logic             w_fault_a, w_fault_b;

  assign w_tick    = (r_cnt == LP_CNT_LAST);
  assign w_route_a = (SW == 3'b000);
  assign w_route_b = (SW == 3'b011);

  // Movement tick divider: counts 0..SPEED_DIV-1, tick on the last count.
  always_ff @(posedge Clock or negedge RESET) begin
    if (!RESET) r_cnt <= '0;
    else        r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
  end

`ifdef TRAIN_LAP_COUNT_EN
  logic w_wrap_a, w_wrap_b;
`endif

  train_track_unit #(
    .LOOP_LEN(LOOP_LEN), .POS_W(POS_W),
    .APPROACH_POS(APPROACH_POS), .START_POS(A_START)
  ) u_train_a (
    .i_clk    (Clock),
    .i_rst_n  (RESET),
    .i_tick   (w_tick),
    .i_fwd    (DA == 2'b01),
    .i_routed (w_route_a),
    .o_pos    (w_pos_a),
    .o_fault  (w_fault_a)
`ifdef TRAIN_LAP_COUNT_EN
    ,
    .o_wrap   (w_wrap_a)
`endif
  );

  train_track_unit #(
    .LOOP_LEN(LOOP_LEN), .POS_W(POS_W),
    .APPROACH_POS(APPROACH_POS), .START_POS(B_START)
  ) u_train_b (
    .i_clk    (Clock),
    .i_rst_n  (RESET),
    .i_tick   (w_tick),
    .i_fwd    (DB == 2'b01),
    .i_routed (w_route_b),
    .o_pos    (w_pos_b),
    .o_fault  (w_fault_b)
`ifdef TRAIN_LAP_COUNT_EN
    ,
    .o_wrap   (w_wrap_b)
`endif
  );

  assign POS_A   = w_pos_a;
  assign POS_B   = w_pos_b;
  assign FAULT_A = w_fault_a;
  assign FAULT_B = w_fault_b;

  // Sensors are a pure decode of the position registers.
  assign SR[1] = (w_pos_a == LP_APPROACH);
  assign SR[2] = (w_pos_b == LP_APPROACH);
  assign SR[3] = (w_pos_b == LP_EXIT);
  assign SR[4] = (w_pos_a == LP_EXIT);

  assign w_a_in    = (w_pos_a >= LP_ENTRY) && (w_pos_a < LP_EXIT);
  assign w_b_in    = (w_pos_b >= LP_ENTRY) && (w_pos_b < LP_EXIT);
  assign w_both_in = w_a_in && w_b_in;

  // Sticky collision latch; the output also shows the current-cycle overlap
  // so the flag is visible in the very cycle both trains are inside.
  always_ff @(posedge Clock or negedge RESET) begin
    if (!RESET) r_collide <= 1'b0;
    else        r_collide <= r_collide | w_both_in;
  end

  assign COLLIDE = r_collide | w_both_in;

`ifdef TRAIN_LAP_COUNT_EN
  logic [7:0] r_laps_a, r_laps_b;

  // Saturating lap counters, bumped on each LOOP_LEN-1 -> 0 wrap.
  always_ff @(posedge Clock or negedge RESET) begin
    if (!RESET) begin
      r_laps_a <= 8'd0;
      r_laps_b <= 8'd0;
    end else begin
      if (w_wrap_a && r_laps_a != 8'hFF) r_laps_a <= r_laps_a + 8'd1;
      if (w_wrap_b && r_laps_b != 8'hFF) r_laps_b <= r_laps_b + 8'd1;
    end
  end

  assign LAPS_A = r_laps_a;
  assign LAPS_B = r_laps_b;
`endif

endmodule
